// File: rtl/sa_skew_feeder.sv
// Operand feeder for the sa systolic array: a ping-pong frame buffer on the write side,
// replayed as a diagonal wavefront (lane i delayed by i cycles) with a fixed zero gap between frames.
module sa_skew_feeder #(
    parameter int DIMENSION = 4,
    parameter int GAP       = 10
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic                              S_VALID,
    output logic                              S_READY,
    input  logic                              S_LAST,
    input  logic [1:0][DIMENSION-1:0][15:0]   S_DATA,
    output logic [DIMENSION-1:0]              DVI,
    output logic [1:0][DIMENSION-1:0][15:0]   DI,
    output logic                              BUSY,
    output logic                              ERR
);

    localparam int IW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
    localparam int TW = $clog2(2 * DIMENSION);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(2 * DIMENSION - 2);
    localparam logic [IW-1:0] K_LAST = IW'(DIMENSION - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_GAP
    } state_t;

    state_t                             state;
    logic [TW-1:0]                      t;
    logic [GW-1:0]                      g;
    logic                               rd_bank;
    logic                               wr_bank;
    logic [IW-1:0]                      wr_idx;
    logic [1:0]                         full;
    logic [1:0][DIMENSION-1:0][15:0]    mem [2][DIMENSION];

    logic                               accept;
    logic                               fill;
    logic                               free;
    logic [1:0]                         full_post;
    logic                               wr_bank_post;
    logic [DIMENSION-1:0]               dvi_nxt;
    logic [1:0][DIMENSION-1:0][15:0]    di_nxt;
    logic [IW-1:0]                      beat;

    assign accept       = S_VALID && S_READY;
    assign fill         = accept && (wr_idx == K_LAST);
    assign free         = (state == ST_STREAM) && (t == T_LAST);
    assign wr_bank_post = wr_bank ^ fill;
    assign BUSY         = (state != ST_IDLE);

    // A fill and a free in the same cycle always touch different banks.
    always_comb begin
        full_post = full;
        if (fill) full_post[wr_bank] = 1'b1;
        if (free) full_post[rd_bank] = 1'b0;
    end

    always_comb begin
        dvi_nxt = '0;
        di_nxt  = '0;
        beat    = '0;
        if (state == ST_STREAM) begin
            for (int i = 0; i < DIMENSION; i++) begin
                if (t >= TW'(i) && (t - TW'(i)) < TW'(DIMENSION)) begin
                    beat          = IW'(t - TW'(i));
                    dvi_nxt[i]    = 1'b1;
                    di_nxt[0][i]  = mem[rd_bank][beat][0][i];
                    di_nxt[1][i]  = mem[rd_bank][beat][1][i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) mem[wr_bank][wr_idx] <= S_DATA;
    end

    // Outputs lag the state by one edge, so the first lane fires two edges after the frame fills.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= ST_IDLE;
            t       <= '0;
            g       <= '0;
            rd_bank <= 1'b0;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            full    <= '0;
            S_READY <= 1'b0;
            ERR     <= 1'b0;
            DVI     <= '0;
            DI      <= '0;
        end else begin
            full    <= full_post;
            wr_bank <= wr_bank_post;
            S_READY <= !full_post[wr_bank_post];
            DVI     <= dvi_nxt;
            DI      <= di_nxt;
            if (accept) begin
                wr_idx <= fill ? '0 : wr_idx + 1'b1;
                if (S_LAST != (wr_idx == K_LAST)) ERR <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (full[rd_bank]) begin
                        state <= ST_STREAM;
                        t     <= '0;
                    end
                end
                ST_STREAM: begin
                    if (t == T_LAST) begin
                        rd_bank <= ~rd_bank;
                        if (GAP > 0) begin
                            state <= ST_GAP;
                            g     <= '0;
                        end else if (full[~rd_bank]) begin
                            t <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (g == G_LAST) begin
                        if (full[rd_bank]) begin
                            state <= ST_STREAM;
                            t     <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        g <= g + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder: frames are driven in a linear sequence, array-side outputs are
// logged every cycle and compared against a formula model of the skewed wavefront.
module tb_sa_skew_feeder;

    localparam int D    = 4;
    localparam int LOGN = 4096;

    logic                       CLK = 1'b0;
    logic                       RSTn = 1'b0;
    logic                       S_VALID = 1'b0;
    logic                       S_LAST = 1'b0;
    logic                       S_READY;
    logic [1:0][D-1:0][15:0]    S_DATA = '0;
    logic [D-1:0]               DVI;
    logic [1:0][D-1:0][15:0]    DI;
    logic                       BUSY;
    logic                       ERR;

    int nCmp = 0;
    int nBad = 0;
    int cyc  = 0;

    logic [D-1:0]  dviLog  [LOGN];
    logic [127:0]  diLog   [LOGN];
    logic          rdyLog  [LOGN];
    logic          busyLog [LOGN];

    sa_skew_feeder #(.DIMENSION(D), .GAP(10)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .S_VALID (S_VALID),
        .S_READY (S_READY),
        .S_LAST  (S_LAST),
        .S_DATA  (S_DATA),
        .DVI     (DVI),
        .DI      (DI),
        .BUSY    (BUSY),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Entry c holds the outputs as they stood after rising edge number c.
    always @(negedge CLK) begin
        if (cyc < LOGN) begin
            dviLog[cyc]  <= DVI;
            diLog[cyc]   <= DI;
            rdyLog[cyc]  <= S_READY;
            busyLog[cyc] <= BUSY;
        end
    end

    function automatic logic [15:0] opA(int f, int k, int i);
        return {8'h1A + 8'(f * 16), 4'(i + 1), 4'(D - k)};
    endfunction

    function automatic logic [15:0] opB(int f, int k, int i);
        return {8'h1B + 8'(f * 16), 4'(D - k), 4'(i + 1)};
    endfunction

    function automatic logic [1:0][D-1:0][15:0] makeBeat(int f, int k);
        logic [1:0][D-1:0][15:0] b;
        for (int i = 0; i < D; i++) begin
            b[0][i] = opA(f, k, i);
            b[1][i] = opB(f, k, i);
        end
        return b;
    endfunction

    function automatic logic [D-1:0] expDvi(int c);
        logic [D-1:0] r = '0;
        for (int i = 0; i < D; i++)
            if (c >= i && c - i < D) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [127:0] expDi(int f, int c);
        logic [1:0][D-1:0][15:0] r = '0;
        for (int i = 0; i < D; i++) begin
            if (c >= i && c - i < D) begin
                r[0][i] = opA(f, c - i, i);
                r[1][i] = opB(f, c - i, i);
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Presents beat k of frame f and returns the edge number on which it was accepted.
    task automatic applyStimulus(input int f, input int k, input logic last, output int edgeNo);
        int waitCnt = 0;
        S_VALID = 1'b1;
        S_DATA  = makeBeat(f, k);
        S_LAST  = last;
        while (S_READY !== 1'b1 && waitCnt < 200) begin
            @(posedge CLK);
            #1;
            waitCnt++;
        end
        checkOutput($sformatf("ready_f%0d_k%0d", f, k), 128'(S_READY), 128'(1));
        @(posedge CLK);
        #1;
        edgeNo = cyc;
    endtask

    task automatic sendFrame(input int f, output int lastEdge);
        for (int k = 0; k < D; k++) applyStimulus(f, k, k == D - 1, lastEdge);
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
    endtask

    task automatic checkWave(input string tag, input int f, input int start);
        checkOutput($sformatf("%s_pre_dvi", tag), 128'(dviLog[start-1]), 128'(0));
        for (int c = 0; c < 2 * D; c++) begin
            checkOutput($sformatf("%s_dvi_c%0d", tag, c), 128'(dviLog[start+c]), 128'(expDvi(c)));
            checkOutput($sformatf("%s_di_c%0d", tag, c), diLog[start+c], expDi(f, c));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e, e1, e2, s1;

        #12;
        checkOutput("rst_dvi", 128'(DVI), 128'(0));
        checkOutput("rst_di", DI, 128'(0));
        checkOutput("rst_ready", 128'(S_READY), 128'(0));
        checkOutput("rst_busy", 128'(BUSY), 128'(0));
        checkOutput("rst_err", 128'(ERR), 128'(0));
        RSTn = 1'b1;
        #1;
        checkOutput("ready_before_edge", 128'(S_READY), 128'(0));
        tick(1);
        checkOutput("ready_after_edge", 128'(S_READY), 128'(1));

        $display("[TB] scenario 1: single frame, no stalls");
        sendFrame(0, e);
        tick(30);
        checkWave("s1", 0, e + 2);
        checkOutput("s1_t3_A", 128'(diLog[e+5][63:0]), 128'(64'h1A44_1A33_1A22_1A11));
        checkOutput("s1_t3_B", 128'(diLog[e+5][127:64]), 128'(64'h1B44_1B33_1B22_1B11));
        checkOutput("s1_t6_A", 128'(diLog[e+8][63:0]), 128'(64'h1A41_0000_0000_0000));
        checkOutput("s1_busy_idle", 128'(busyLog[e]), 128'(0));
        checkOutput("s1_busy_stream", 128'(busyLog[e+1]), 128'(1));
        checkOutput("s1_err", 128'(ERR), 128'(0));

        $display("[TB] scenario 2: upstream stall between beats 1 and 2");
        applyStimulus(0, 0, 1'b0, e);
        applyStimulus(0, 1, 1'b0, e);
        S_VALID = 1'b0;
        tick(5);
        applyStimulus(0, 2, 1'b0, e);
        applyStimulus(0, 3, 1'b1, e);
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
        tick(30);
        checkWave("s2", 0, e + 2);

        $display("[TB] scenarios 3/4: three frames with valid held high");
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < D; k++) begin
                applyStimulus(f, k, k == D - 1, e);
                if (f == 0 && k == D - 1) e1 = e;
                if (f == 1 && k == D - 1) e2 = e;
            end
        end
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
        tick(60);
        s1 = e1 + 2;
        checkWave("s4_f0", 0, s1);
        checkWave("s4_f1", 1, s1 + 17);
        checkWave("s4_f2", 2, s1 + 34);
        for (int c = 7; c < 17; c++) begin
            checkOutput($sformatf("s3_gap1_c%0d", c), 128'(dviLog[s1+c]), 128'(0));
            checkOutput($sformatf("s3_gap2_c%0d", c), 128'(dviLog[s1+17+c]), 128'(0));
        end
        checkOutput("s4_f1_fill_edge", 128'(e2), 128'(e1 + 4));
        checkOutput("s4_ready_before_fill2", 128'(rdyLog[e2-1]), 128'(1));
        checkOutput("s4_ready_drop", 128'(rdyLog[e2]), 128'(0));
        checkOutput("s4_ready_still_low", 128'(rdyLog[s1+5]), 128'(0));
        checkOutput("s4_ready_reassert", 128'(rdyLog[s1+6]), 128'(1));
        checkOutput("s4_err", 128'(ERR), 128'(0));

        $display("[TB] scenario 5: misplaced S_LAST");
        applyStimulus(0, 0, 1'b0, e);
        checkOutput("s5_err_beat0", 128'(ERR), 128'(0));
        applyStimulus(0, 1, 1'b1, e);
        checkOutput("s5_err_beat1", 128'(ERR), 128'(1));
        applyStimulus(0, 2, 1'b0, e);
        applyStimulus(0, 3, 1'b0, e);
        S_VALID = 1'b0;
        tick(30);
        checkWave("s5", 0, e + 2);
        checkOutput("s5_err_sticky", 128'(ERR), 128'(1));

        $display("[TB] scenario 6: reset during stream");
        sendFrame(0, e);
        tick(5);
        checkOutput("s6_pre_rst_dvi", 128'(DVI), 128'(4'b1111));
        #1;
        RSTn = 1'b0;
        #1;
        checkOutput("s6_rst_dvi", 128'(DVI), 128'(0));
        checkOutput("s6_rst_di", DI, 128'(0));
        checkOutput("s6_rst_ready", 128'(S_READY), 128'(0));
        checkOutput("s6_rst_busy", 128'(BUSY), 128'(0));
        checkOutput("s6_rst_err", 128'(ERR), 128'(0));
        #1;
        RSTn = 1'b1;
        tick(1);
        checkOutput("s6_ready_after", 128'(S_READY), 128'(1));
        tick(3);
        checkOutput("s6_dropped_busy", 128'(BUSY), 128'(0));
        checkOutput("s6_dropped_dvi", 128'(DVI), 128'(0));
        sendFrame(0, e);
        tick(30);
        checkWave("s6", 0, e + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
Upstream feeder for the sa systolic array. It accepts one operand frame of DIMENSION beats over a valid/ready stream. Each beat carries one A-vector and one B-vector. Frames are held in a ping-pong buffer, then replayed to the array as a contiguous diagonal wavefront: lane i is delayed by i cycles, and DVI is generated to match. Upstream stalls never put bubbles into the array.

Parameters:
DIMENSION, 4, array size: lanes per operand and beats per frame
GAP, 10, minimum all-zero cycles on the array side between two consecutive wavefronts (0 allowed)

Ports:
CLK  in  1  clock
RSTn  in  1  asynchronous active-low reset
S_VALID  in  1  upstream beat valid
S_READY  out  1  feeder can accept a beat (registered)
S_LAST  in  1  upstream marks beat DIMENSION-1 of a frame
S_DATA  in  [1:0][DIMENSION-1:0][15:0]  beat k: [0][i]=A operand for lane i, [1][i]=B operand for lane i (float16)
DVI  out  DIMENSION  per-lane valid to sa.DVI
DI  out  [1:0][DIMENSION-1:0][15:0]  per-lane operands to sa.DI
BUSY  out  1  a wavefront or a gap is in progress
ERR  out  1  sticky S_LAST framing error

Behaviour:
- Reset (async, RSTn=0):
  - DVI=0, DI=0, S_READY=0, BUSY=0, ERR=0.
  - Both banks are empty, the write pointer is at bank0 beat0, and the FSM is IDLE.
  - S_READY rises on the first CLK edge after RSTn deasserts.
  - Reset mid-stream drops all buffered data immediately; a partial frame is discarded.
- Write side:
  - A beat is accepted on an edge where S_VALID and S_READY are both 1.
  - The beat is stored at write-bank[k], and k increments.
  - When k reaches DIMENSION, the bank is marked full, the write bank toggles, and k returns to 0.
  - S_READY=0 when the next write bank is full, including the edge that fills the second bank.
  - Upstream gaps of any length between beats are legal.
- Framing:
  - Framing is purely by count; S_LAST never shortens or extends a frame.
  - ERR sets if S_LAST=1 on an accepted beat other than DIMENSION-1, or S_LAST=0 on beat DIMENSION-1.
  - ERR stays set until reset.
- Read FSM states:
  - IDLE: the read bank is not full. If it is full, go to STREAM with t=0.
  - STREAM: t counts 0..2*DIMENSION-2.
    - Registered outputs per lane i: DVI[i]=1 iff 0<=t-i<DIMENSION.
    - DI[s][i]=bank[t-i][s][i] when DVI[i]=1, else 0.
    - After t=2*DIMENSION-2, free the read bank and toggle the read bank.
    - Go to GAP if GAP>0, else to IDLE/STREAM per bank state.
  - GAP: count GAP cycles with DVI=0 and DI=0, then go to IDLE. If the next bank is already full, go directly to STREAM.
- BUSY=1 in STREAM and GAP.
- Latency: if the final beat of a frame is accepted at edge E while the FSM is IDLE, then DVI=...0001 is visible from edge E+2.
- Throughput with both banks kept full: wavefront of 2*DIMENSION-1 cycles, then GAP zero cycles, repeating with no extra idle cycle.
- Simultaneous events:
  - A write filling bank X on the same edge that STREAM frees bank Y is legal.
  - S_READY follows from the post-edge full flags.

Test Plan:
1. DIMENSION=4. Beat k lane i: A=16'h1A{i+1}{4-k}, B=16'h1B{4-k}{i+1}, S_LAST on beat 3, no stalls.
   - DVI over 7 cycles: 0001,0011,0111,1111,1110,1100,1000, then 0.
   - At t=3: DI[0]={1A44,1A33,1A22,1A11} and DI[1]={1B44,1B33,1B22,1B11}.
   - At t=6: DI[0]={1A41,0,0,0}. ERR=0.
2. Same frame with S_VALID low for 5 cycles between beats 1 and 2.
   - Output sequence identical to scenario 1, starting 2 edges after beat 3 is accepted; no mid-wavefront zeros.
3. Two frames back-to-back, GAP=10.
   - Second frame is loaded during the first wavefront.
   - The second wavefront's 0001 appears exactly 10 zero cycles after the first wavefront's 1000 cycle.
4. Three frames with S_VALID held high.
   - S_READY drops after frame 2 fills, and reasserts on the edge after wavefront 1 frees its bank.
   - All 12 beats appear on DI in order; none are lost or duplicated.
5. S_LAST=1 on beat 1 and S_LAST=0 on beat 3.
   - ERR=1 from the edge after beat 1 and stays set.
   - The frame still streams as 4 beats, bit-identical to scenario 1.
6. RSTn pulsed low during STREAM at t=3.
   - DVI, DI, S_READY, BUSY and ERR go to 0 asynchronously.
   - After release, a fresh scenario-1 frame reproduces scenario 1's output exactly.
